comparator_multicycle: RTL
==========================

COMPARATOR_MULTICYCLE -- requirements
Module: comparator_multicycle

Interface
REQ-001 SHALL have parameter N, default 32: operand width in bits.
REQ-002 SHALL have parameter W, default 8: chunk width compared per cycle; N % W == 0 and W <= N are required, and elaboration SHALL fail otherwise.
REQ-003 SHALL have localparam NCHUNK = N/W, and a chunk counter of width max(1, $clog2(NCHUNK)).
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Ports, in order:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  operands present
- i_ready  output  1  block can accept operands
- a  input  N  operand A
- b  input  N  operand B
- is_signed  input  1  1 = two's-complement compare; 0 = unsigned compare
- o_valid  output  1  result present
- o_ready  input  1  consumer accepts result
- equals  output  1  a == b
- less_than  output  1  a < b under the captured mode
- o_cycles  output  max(1, $clog2(NCHUNK+1))  number of scan cycles used

Function
REQ-006 FSM states SHALL be S_IDLE, S_SCAN and S_DONE.
REQ-007 i_ready SHALL equal (state == S_IDLE) and be purely combinational from state.
REQ-008 On the rising edge with i_valid && i_ready, the block SHALL:
- register a, b and is_signed;
- load the chunk index with NCHUNK-1, so the MSB chunk is compared first;
- enter S_SCAN.
REQ-009 Inputs SHALL be ignored outside S_IDLE; registered operands SHALL NOT change until the next accept.
REQ-010 Each S_SCAN cycle SHALL compare one W-bit chunk of the registered operands.
- For the top chunk in signed mode, the MSB of both chunks is inverted before an unsigned compare.
- All other chunks are compared unsigned.
REQ-011 If the chunks differ, the next edge SHALL enter S_DONE with equals=0 and less_than = (chunk_a < chunk_b).
REQ-012 If the chunks are equal and the index is 0, the next edge SHALL enter S_DONE with equals=1 and less_than=0.
REQ-013 If the chunks are equal and the index is greater than 0, the index SHALL decrement and the FSM SHALL stay in S_SCAN.
REQ-014 Latency: with accept at edge t0, o_valid SHALL rise at edge t0+m.
- m = 1-based position, from the MSB end, of the first differing chunk.
- m = NCHUNK if a == b.
- o_cycles SHALL equal m.
REQ-015 In S_DONE, o_valid=1; equals, less_than and o_cycles SHALL be held stable until o_valid && o_ready.
REQ-016 On the edge with o_valid && o_ready, the FSM SHALL return to S_IDLE.
- o_valid falls on that edge.
- A new accept is possible no earlier than the following edge; there is no same-cycle turnaround.
REQ-017 equals and less_than SHALL keep their last values while in S_IDLE and S_SCAN; they are meaningful only when o_valid=1.
REQ-018 When NCHUNK=1 (W=N), every compare SHALL complete with m=1.

Reset
REQ-019 rst_n low SHALL immediately force:
- state = S_IDLE;
- o_valid=0, equals=0, less_than=0, o_cycles=0;
- registered operands and chunk index = 0.
REQ-020 Reset asserted during S_SCAN or S_DONE SHALL discard the operation; no o_valid pulse follows deassertion.
REQ-021 Reset deassertion SHALL take effect on the next rising edge; i_ready=1 from then on.

Structure
REQ-022 The package comparator_pkg SHALL hold:
- typedef enum logic [1:0] comparator_state_t {S_IDLE, S_SCAN, S_DONE};
- any shared width-helper functions.
REQ-023 One sub-module, comparator_chunk #(W), SHALL be instantiated once.
- Inputs: two W-bit chunks and an invert_msb flag.
- Outputs: combinational chunk_eq and chunk_lt.
REQ-024 The implementation SHALL contain no other combinational path from a/b to outputs; all outputs are registered except i_ready.

Verification (N=32, W=8 unless stated)
REQ-025 a=0, b=0, unsigned -> o_valid 4 cycles after accept; equals=1, less_than=0, o_cycles=4.
REQ-026 a=32'hFFFFFFFF, b=1:
- signed -> 1 cycle, equals=0, less_than=1, o_cycles=1;
- unsigned -> 1 cycle, less_than=0.
REQ-027 a=32'h7FFFFFFF, b=32'h80000000:
- signed -> less_than=0;
- unsigned -> less_than=1;
- both o_cycles=1.
REQ-028 a=32'h12345678, b=32'h12345778 -> o_cycles=3, equals=0, less_than=1.
REQ-029 Backpressure: hold o_ready=0 for 5 cycles after o_valid -> outputs stable, i_ready=0 throughout; o_ready=1 -> i_ready=1 on the next cycle.
REQ-030 Reset and random checks:
- rst_n pulsed low mid-S_SCAN -> o_valid=0, i_ready=1 after release, no stale result;
- 1000 random a/b/is_signed vectors, also run with W=4, checked against the behavioural signed/unsigned == and <, with 4-state (===) checks.

Source files
------------

// File: rtl/comparator_pkg.sv
// Shared types and width helpers for the multi-cycle chunked comparator.
// No logic of its own; imported by comparator_chunk and comparator_multicycle.
package comparator_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } comparator_state_t;

    // Counter width for a value range of v, never narrower than one bit.
    function automatic int width_of(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/comparator_chunk.sv
// Single W-bit chunk compare; purely combinational, zero latency, no backpressure.
// invert_msb turns the unsigned compare into a two's-complement one for the top chunk.
module comparator_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] chunk_a_i,
    input  logic [W-1:0] chunk_b_i,
    input  logic         invert_msb_i,
    output logic         chunk_eq_o,
    output logic         chunk_lt_o
);

    logic [W-1:0] msb_mask;
    logic [W-1:0] ca;
    logic [W-1:0] cb;

    assign msb_mask   = {W{invert_msb_i}} & (W'(1) << (W - 1));
    assign ca         = chunk_a_i ^ msb_mask;
    assign cb         = chunk_b_i ^ msb_mask;
    assign chunk_eq_o = (ca == cb);
    assign chunk_lt_o = (ca < cb);

endmodule

// File: rtl/comparator_multicycle.sv
// Compares two N-bit operands one W-bit chunk per cycle, MSB chunk first, stopping early.
// Latency: m cycles from accept (m = first differing chunk from the top); result held until o_ready.
module comparator_multicycle
    import comparator_pkg::*;
#(
    parameter  int N      = 32,
    parameter  int W      = 8,
    localparam int NCHUNK = N / W,
    localparam int IW     = width_of(NCHUNK),
    localparam int CW     = width_of(NCHUNK + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  logic          is_signed,
    output logic          o_valid,
    input  logic          o_ready,
    output logic          equals,
    output logic          less_than,
    output logic [CW-1:0] o_cycles
);

    if (W < 1 || W > N || (N % W) != 0) begin : g_bad_params
        $error("comparator_multicycle: W must divide N and satisfy 1 <= W <= N");
    end

    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    comparator_state_t state_q, state_d;
    logic [N-1:0]  a_q, a_d, b_q, b_d;
    logic          sign_q, sign_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          eq_q, eq_d, lt_q, lt_d;
    logic [CW-1:0] cyc_q, cyc_d;

    logic [W-1:0]  chunk_a, chunk_b;
    logic          chunk_eq, chunk_lt;

    assign chunk_a = a_q[int'(idx_q) * W +: W];
    assign chunk_b = b_q[int'(idx_q) * W +: W];

    comparator_chunk #(.W(W)) u_chunk (
        .chunk_a_i    (chunk_a),
        .chunk_b_i    (chunk_b),
        .invert_msb_i (sign_q && (idx_q == LAST_IDX)),
        .chunk_eq_o   (chunk_eq),
        .chunk_lt_o   (chunk_lt)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sign_d  = sign_q;
        idx_d   = idx_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        cyc_d   = cyc_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sign_d  = is_signed;
                    idx_d   = LAST_IDX;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                // Chunks already scanned, including this one, is NCHUNK - idx.
                if (!chunk_eq || idx_q == '0) begin
                    state_d = S_DONE;
                    eq_d    = chunk_eq;
                    lt_d    = chunk_lt;
                    cyc_d   = CW'(NCHUNK) - CW'(idx_q);
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            S_DONE: begin
                if (o_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            idx_q   <= '0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            idx_q   <= idx_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            cyc_q   <= cyc_d;
        end
    end

    assign i_ready   = (state_q == S_IDLE);
    assign o_valid   = (state_q == S_DONE);
    assign equals    = eq_q;
    assign less_than = lt_q;
    assign o_cycles  = cyc_q;

endmodule
